// File: rtl/dmem_sram.sv
// dmem_sram: word-organised data-memory slave on the valid/ready bus.
// A request is latched when accepted in IDLE. It then spends a programmable
// number of wait states in BUSY, which the external stall_i can stretch, and
// completes with a single-cycle ready pulse. Stores are byte-masked by wstrb.
// Loads return a full word, which is held on dmem_rdata until the next load.
module dmem_sram #(
    parameter int XLEN        = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmem_valid,
    input  logic            dmem_write,
    input  logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_ready,
    input  logic            stall_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  commit;
    logic [XLEN-1:0]       mem_word;

    // The byte offset and the address bits above the array size are
    // deliberately ignored, so addresses wrap and accesses are word-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[XLEN-1:DEPTH_LOG2+2], dmem_addr[1:0]};

    // Next-state and output logic. The request is captured only at IDLE
    // acceptance, so any change on the bus while BUSY has no effect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        wstrb_d = wstrb_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dmem_valid) begin
                    write_d = dmem_write;
                    wstrb_d = dmem_wstrb;
                    idx_d   = dmem_addr[DEPTH_LOG2+1:2];
                    wdata_d = dmem_wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!dmem_valid) begin
                    // The master withdrew the request: drop it without touching memory.
                    state_d = S_IDLE;
                end else if (stall_i) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                    if (!write_q) begin
                        rdata_d = mem_word;
                    end
                end
            end
            S_RESP: begin
                // dmem_valid is ignored here, so a request held across the
                // ready cycle is accepted at the following edge in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers. The memory array has no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            wstrb_q <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            wstrb_q <= wstrb_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Each byte lane is its own array, so a strobe is simply that lane's
    // write enable.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            // Masked store into this lane at the commit edge.
            always_ff @(posedge clk) begin
                if (commit && write_q && wstrb_q[gi]) begin
                    mem[idx_q] <= wdata_q[8*gi +: 8];
                end
            end

            assign mem_word[8*gi +: 8] = mem[idx_q];
        end
    endgenerate

    assign dmem_rdata = rdata_q;
    assign dmem_ready = ready_q;

endmodule

// File: tb/tb_dmem_sram.sv
// Bench for dmem_sram. Two instances are used, one with no wait states and one
// with three. Each access is predicted by a word-array reference model. The
// latency model is: the ready pulse follows accept + 1 + WAIT_STATES + stalls.
module tb_dmem_sram;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk;
    logic        rst_n;
    logic        valid [2];
    logic        write [2];
    logic        stall [2];
    logic [3:0]  wstrb [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];

    logic [31:0] model_mem   [2][1024];
    logic [31:0] model_rdata [2];

    int checks = 0;
    int passes = 0;

    dmem_sram #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dmem_valid(valid[0]), .dmem_write(write[0]),
        .dmem_wstrb(wstrb[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
        .dmem_rdata(rdata[0]), .dmem_ready(ready[0]), .stall_i(stall[0])
    );

    dmem_sram #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dmem_valid(valid[1]), .dmem_write(write[1]),
        .dmem_wstrb(wstrb[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
        .dmem_rdata(rdata[1]), .dmem_ready(ready[1]), .stall_i(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    // One complete access with nstall stalled BUSY edges. The request fields
    // are scrambled while BUSY to show that only the accepted values matter.
    task automatic access(input int d, input bit wr, input logic [3:0] strb,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int nstall, input string tag);
        int n;
        int idx;
        int exp_lat;
        logic [31:0] exp_rd;
        idx = int'(a[11:2]);
        exp_lat = ws(d) + 1 + nstall;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            model_rdata[d] = model_mem[d][idx];
        end
        exp_rd = model_rdata[d];

        @(negedge clk);
        valid[d] = 1'b1; write[d] = wr; wstrb[d] = strb;
        addr[d] = a; wdata[d] = wd; stall[d] = (nstall > 0);
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            stall[d] = (n < nstall);
            write[d] = 1'($urandom);
            wstrb[d] = 4'($urandom);
            addr[d]  = $urandom;
            wdata[d] = $urandom;
            @(posedge clk);
            n++;
            #1;
            if (ready[d] === 1'b1 || n > 60) break;
        end
        valid[d] = 1'b0;
        stall[d] = 1'b0;

        checks++;
        if (n !== exp_lat)
            $display("FAIL %s latency dut%0d: got %0d edges, expected %0d", tag, d, n, exp_lat);
        else passes++;
        checks++;
        if (rdata[d] !== exp_rd)
            $display("FAIL %s rdata dut%0d: got %h, expected %h", tag, d, rdata[d], exp_rd);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (ready[d] !== 1'b0)
            $display("FAIL %s pulse dut%0d: ready got %b, expected 0", tag, d, ready[d]);
        else passes++;
        $display("txn %s dut%0d %s a=%h strb=%h wd=%h stall=%0d lat=%0d rdata=%h",
                 tag, d, wr ? "ST" : "LD", a, strb, wd, nstall, n, rdata[d]);
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 0; write[d] = 0; stall[d] = 0; wstrb[d] = 0; addr[d] = 0; wdata[d] = 0;
            model_rdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b0) $display("FAIL reset_ready dut%0d: got %b, expected 0", d, ready[d]);
            else passes++;
            checks++;
            if (rdata[d] !== 32'h0) $display("FAIL reset_rdata dut%0d: got %h, expected 0", d, rdata[d]);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (ready[d] !== 1'b0) seen = 1;
            end
            checks++;
            if (seen) $display("FAIL idle_ready dut%0d: ready rose with valid=0, expected 0", d);
            else passes++;
        end
    endtask

    task automatic test_basic();
        for (int d = 0; d < 2; d++) begin
            access(d, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0, "basic_st");
            access(d, 0, 4'h0, 32'h40, 32'h0, 0, "basic_ld");
            checks++;
            if (rdata[d] !== 32'hDEADBEEF) $display("FAIL basic_value dut%0d: got %h, expected deadbeef", d, rdata[d]);
            else passes++;
        end
    endtask

    task automatic test_strobes();
        for (int d = 0; d < 2; d++) begin
            access(d, 1, 4'hF, 32'h80, 32'h11223344, 0, "strb_init");
            access(d, 1, 4'b0101, 32'h80, 32'hAABBCCDD, 0, "strb_st");
            access(d, 1, 4'b0000, 32'h80, 32'hFFFFFFFF, 0, "strb_zero");
            access(d, 0, 4'hF, 32'h80, 32'h0, 0, "strb_ld");
            checks++;
            if (rdata[d] !== 32'h11BB33DD) $display("FAIL strb_value dut%0d: got %h, expected 11bb33dd", d, rdata[d]);
            else passes++;
        end
    endtask

    task automatic test_wait_stall();
        access(1, 1, 4'hF, 32'hC0, 32'hCAFEF00D, 2, "stall_st");
        access(1, 0, 4'h0, 32'hC0, 32'h0, 2, "stall_ld");
        access(0, 1, 4'hF, 32'hC0, 32'h0BADF00D, 3, "stall_st0");
        access(0, 0, 4'h0, 32'hC0, 32'h0, 1, "stall_ld0");
    endtask

    task automatic test_wrap();
        access(0, 1, 4'hF, 32'h1003, 32'h5, 0, "wrap_st");
        access(0, 0, 4'h0, 32'h0000, 32'h0, 0, "wrap_ld");
        checks++;
        if (rdata[0] !== 32'h5) $display("FAIL wrap_value: got %h, expected 00000005", rdata[0]);
        else passes++;
        access(1, 1, 4'hF, 32'hFFFFF106, 32'h76543210, 0, "wrap_hi_st");
        access(1, 0, 4'h0, 32'h00000105, 32'h0, 0, "wrap_hi_ld");
    endtask

    // Two loads with valid held high throughout; ready pulses are WS+3 apart.
    task automatic test_back_to_back();
        int t, t1, t2;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            valid[d] = 1; write[d] = 0; wstrb[d] = 4'h0; addr[d] = 32'h40; stall[d] = 0;
            @(posedge clk);
            t = 0; t1 = -1; t2 = -1;
            while (t < 100) begin
                @(posedge clk);
                t++;
                #1;
                if (ready[d] === 1'b1) begin
                    if (t1 < 0) begin
                        t1 = t;
                        checks++;
                        if (rdata[d] !== model_mem[d][16]) $display("FAIL b2b_rd0 dut%0d: got %h, expected %h", d, rdata[d], model_mem[d][16]);
                        else passes++;
                        addr[d] = 32'h80;
                    end else begin
                        t2 = t;
                        break;
                    end
                end
            end
            valid[d] = 0;
            model_rdata[d] = model_mem[d][32];
            checks++;
            if (t1 !== ws(d) + 1) $display("FAIL b2b_first dut%0d: got %0d, expected %0d", d, t1, ws(d) + 1);
            else passes++;
            checks++;
            if (t2 - t1 !== ws(d) + 3) $display("FAIL b2b_spacing dut%0d: got %0d, expected %0d", d, t2 - t1, ws(d) + 3);
            else passes++;
            checks++;
            if (rdata[d] !== model_rdata[d]) $display("FAIL b2b_rd1 dut%0d: got %h, expected %h", d, rdata[d], model_rdata[d]);
            else passes++;
            $display("txn b2b dut%0d first=%0d second=%0d rdata=%h", d, t1, t2, rdata[d]);
            @(posedge clk);
        end
    endtask

    task automatic test_abort();
        bit seen;
        access(1, 1, 4'hF, 32'h200, 32'h12345678, 0, "abort_init");
        @(negedge clk);
        valid[1] = 1; write[1] = 1; wstrb[1] = 4'hF; addr[1] = 32'h200; wdata[1] = 32'hFFFF0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        valid[1] = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (ready[1] !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) $display("FAIL abort_ready: ready pulsed after abort, expected 0");
        else passes++;
        $display("txn abort dut1 ST a=00000200 dropped");
        access(1, 0, 4'h0, 32'h200, 32'h0, 0, "abort_ld");
    endtask

    task automatic test_reset_mid();
        access(1, 1, 4'hF, 32'h300, 32'hA5A5A5A5, 0, "rst_init");
        access(0, 0, 4'h0, 32'h40, 32'h0, 0, "rst_prime");
        @(negedge clk);
        valid[1] = 1; write[1] = 1; wstrb[1] = 4'hF; addr[1] = 32'h300; wdata[1] = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 0;
        valid[1] = 0;
        #1;
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        checks++;
        if (ready[1] !== 1'b0) $display("FAIL rst_mid_ready: got %b, expected 0", ready[1]);
        else passes++;
        checks++;
        if (rdata[0] !== 32'h0) $display("FAIL rst_mid_rdata: got %h, expected 0", rdata[0]);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        $display("txn reset_mid dut1 ST a=00000300 dropped");
        access(1, 0, 4'h0, 32'h300, 32'h0, 0, "rst_ld");
    endtask

    task automatic test_random();
        int pool [16];
        int k;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                pool[i] = int'($urandom_range(1023, 0));
                access(d, 1, 4'hF, 32'(pool[i] * 4), $urandom, 0, "rnd_init");
            end
            for (int i = 0; i < 30; i++) begin
                k = int'($urandom_range(15, 0));
                a = {$urandom_range(255, 0) == 0 ? 20'h0 : 20'($urandom), pool[k][9:0], 2'($urandom)};
                access(d, 1'($urandom), 4'($urandom), a, $urandom,
                       int'($urandom_range(2, 0)), "rnd");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_wait_stall();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
